// File: rtl/ift_rom_fetch_pkg.sv
// rtl/ift_rom_fetch_pkg.sv - shared types and tied constants for the ROM fetch master
// Purpose: FSM state enum, response buffer entry type and the constant ROM
//          control values driven by ift_rom_fetch_master.
package ift_rom_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] taint;
   } fifo_entry_t;

   localparam logic        WEN_TIED   = 1'b1;
   localparam logic [31:0] BE_TIED    = 32'hFFFF_FFFF;
   localparam logic [31:0] WDATA_TIED = 32'h0000_0000;

endpackage

// File: rtl/ift_rom_fetch_fifo.sv
// rtl/ift_rom_fetch_fifo.sv - response buffer for the ROM fetch master
// Purpose: power-of-two deep FIFO of entry_t with synchronous active-high reset.
// Ports:   clk/rst       clock, synchronous active-high reset (flushes contents)
//          push/push_data write side; ignored when full unless a pop happens too
//          pop/head      read side; head is the oldest entry
//          count/empty   occupancy
module ift_rom_fetch_fifo #(
   parameter int  Depth   = 4,
   parameter type entry_t = logic [63:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   output entry_t                   head,
   output logic [$clog2(Depth):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(Depth);

   entry_t          mem [Depth];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     cnt;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign full    = (cnt == (AW+1)'(Depth));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ift_rom_fetch_master.sv
// rtl/ift_rom_fetch_master.sv - burst fetch master reading a ROM into a valid/ready stream
// Purpose: on start_i, reads num_words_i consecutive words from the ROM window
//          (wrapping inside 2^ROM_ADDR_WIDTH bytes) and streams them out with taint.
//          Optional macro IFT_FETCH_ADDR_TAINT_EN: a word fetched with a tainted
//          address gets its data taint forced to all ones.
// Ports:   clk_i/rst_i                 clock, synchronous active-high reset
//          start_i/base_addr_i/base_addr_t0_i/num_words_i  burst command
//          busy_o/done_o               burst status
//          csn_o/wen_o/add_o/add_t0_o/be_o/wdata_o/rdata_i/rdata_t0_i  ROM port
//          data_o/data_t0_o/valid_o/ready_i  output stream
module ift_rom_fetch_master
   import ift_rom_fetch_pkg::*;
#(
   parameter logic [31:0] AddrOffset     = 32'h1A00_0000,
   parameter int          ROM_ADDR_WIDTH = 13,
   parameter int          FifoDepth      = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic [31:0] base_addr_t0_i,
   input  logic [15:0] num_words_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        csn_o,
   output logic        wen_o,
   output logic [31:0] add_o,
   output logic [31:0] add_t0_o,
   output logic [31:0] be_o,
   output logic [31:0] wdata_o,
   input  logic [31:0] rdata_i,
   input  logic [31:0] rdata_t0_i,
   output logic [31:0] data_o,
   output logic [31:0] data_t0_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int CW = $clog2(FifoDepth) + 1;

   state_t                    state;
   state_t                    state_next;
   logic [15:0]               remaining;
   logic [ROM_ADDR_WIDTH-1:0] rom_off;
   logic [31:0]               base_t0;
   logic                      inflight;
   logic                      issue;
   logic                      pop;
   logic                      fifo_empty;
   logic [CW-1:0]             fifo_count;
   logic [CW:0]               credit_used;
   fifo_entry_t               push_entry;
   fifo_entry_t               head_entry;
`ifdef IFT_FETCH_ADDR_TAINT_EN
   logic                      inflight_tainted;
`endif

   assign wen_o   = WEN_TIED;
   assign be_o    = BE_TIED;
   assign wdata_o = WDATA_TIED;

   // Every issued request owns a slot until popped: buffered entries plus the
   // response still on the ROM bus must leave room for this one.
   assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_next = (num_words_i == 16'd0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            busy_o = 1'b1;
            if (remaining != 16'd0 && credit_used < (CW+1)'(FifoDepth)) begin
               issue = 1'b1;
               if (remaining == 16'd1) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            busy_o = 1'b1;
            // Leave as the last word is popped so done_o follows it directly.
            if (!inflight && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign csn_o    = !issue;
   assign add_o    = issue ? (AddrOffset + 32'(rom_off)) : 32'h0;
   assign add_t0_o = issue ? base_t0 : 32'h0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         remaining <= '0;
         rom_off   <= '0;
         base_t0   <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= issue;
         if (state == ST_IDLE && start_i) begin
            remaining <= num_words_i;
            rom_off   <= ROM_ADDR_WIDTH'(base_addr_i - AddrOffset);
            base_t0   <= base_addr_t0_i;
         end else if (issue) begin
            remaining <= remaining - 16'd1;
            rom_off   <= rom_off + ROM_ADDR_WIDTH'(4);
         end
      end
   end

`ifdef IFT_FETCH_ADDR_TAINT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_tainted <= 1'b0;
      end else begin
         inflight_tainted <= issue && (base_t0 != 32'h0);
      end
   end
`endif

   always_comb begin
      push_entry.data = rdata_i;
`ifdef IFT_FETCH_ADDR_TAINT_EN
      push_entry.taint = inflight_tainted ? 32'hFFFF_FFFF : rdata_t0_i;
`else
      push_entry.taint = rdata_t0_i;
`endif
   end

   // inflight is cleared by reset, so a response landing right after reset is dropped.
   ift_rom_fetch_fifo #(
      .Depth   (FifoDepth),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign valid_o   = !fifo_empty;
   assign pop       = valid_o && ready_i;
   assign data_o    = fifo_empty ? 32'h0 : head_entry.data;
   assign data_t0_o = fifo_empty ? 32'h0 : head_entry.taint;

endmodule
